// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache.
// Sits between the fetch stage and the memory controller instruction port.
module icache #(
    parameter int INDEX_BITS = 7,
    parameter int ADDR_BITS  = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        inst_en_i,
    input  logic [31:0] pc_i,
    input  logic        abort_i,
    output logic [31:0] inst_o,
    output logic        inst_rdy_o,
    output logic        mem_en_o,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_inst_i,
    input  logic        mem_rdy_i,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
);

    localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 2;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        MISS,
        RESP
    } state_t;

    state_t state, state_n;

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tags  [LINES];
    logic [31:0]         words [LINES];

    logic [INDEX_BITS-1:0] req_idx, fill_idx;
    logic [TAG_BITS-1:0]   req_tag, fill_tag;
    logic                  hit;
    logic                  accept;
    logic                  fill;
    logic                  fill_resp;
    logic                  aborted;

    assign req_idx  = pc_i[INDEX_BITS+1:2];
    assign req_tag  = pc_i[ADDR_BITS-1:INDEX_BITS+2];
    assign fill_idx = mem_addr_o[INDEX_BITS+1:2];
    assign fill_tag = mem_addr_o[ADDR_BITS-1:INDEX_BITS+2];
    assign hit      = valid[req_idx] && (tags[req_idx] == req_tag);

    // Next-state logic: accept in IDLE, refill in MISS, one-cycle RESP.
    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        fill      = 1'b0;
        fill_resp = 1'b0;
        unique case (state)
            IDLE: begin
                if (inst_en_i && !abort_i) begin
                    accept  = 1'b1;
                    state_n = hit ? RESP : MISS;
                end
            end
            MISS: begin
                if (mem_rdy_i) begin
                    fill      = 1'b1;
                    fill_resp = !(aborted || abort_i);
                    state_n   = fill_resp ? RESP : IDLE;
                end
            end
            RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register; reset wins over the rdy freeze.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else if (rdy) begin
            state <= state_n;
        end
    end

    // Outputs, valid bits, abort tracking and debug counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid      <= '0;
            inst_o     <= '0;
            inst_rdy_o <= 1'b0;
            mem_en_o   <= 1'b0;
            mem_addr_o <= '0;
            aborted    <= 1'b0;
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (rdy) begin
            inst_rdy_o <= 1'b0;
            if (accept) begin
                if (hit) begin
                    inst_o     <= words[req_idx];
                    inst_rdy_o <= 1'b1;
                    hit_cnt_o  <= hit_cnt_o + 32'd1;
                end else begin
                    mem_en_o   <= 1'b1;
                    mem_addr_o <= {pc_i[31:2], 2'b00};
                    aborted    <= 1'b0;
                    miss_cnt_o <= miss_cnt_o + 32'd1;
                end
            end
            if (state == MISS && abort_i) begin
                aborted <= 1'b1;
            end
            if (fill) begin
                valid[fill_idx] <= 1'b1;
                mem_en_o        <= 1'b0;
            end
            if (fill_resp) begin
                inst_o     <= mem_inst_i;
                inst_rdy_o <= 1'b1;
            end
        end
    end

    // Tag and data arrays need no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (rdy && fill) begin
            tags[fill_idx]  <= fill_tag;
            words[fill_idx] <= mem_inst_i;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Randomized self-checking bench for icache.
// A transaction-level line model predicts hits, words and counters.
module tb_icache;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        inst_en_i;
    logic [31:0] pc_i;
    logic        abort_i;
    logic [31:0] inst_o;
    logic        inst_rdy_o;
    logic        mem_en_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_inst_i;
    logic        mem_rdy_i;
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;

    int vec_cnt;
    int err_cnt;

    bit          m_valid [128];
    logic [7:0]  m_tag   [128];
    logic [31:0] m_word  [128];
    logic [31:0] m_hits;
    logic [31:0] m_misses;
    logic [31:0] last;

    icache dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .inst_en_i  (inst_en_i),
        .pc_i       (pc_i),
        .abort_i    (abort_i),
        .inst_o     (inst_o),
        .inst_rdy_o (inst_rdy_o),
        .mem_en_o   (mem_en_o),
        .mem_addr_o (mem_addr_o),
        .mem_inst_i (mem_inst_i),
        .mem_rdy_i  (mem_rdy_i),
        .hit_cnt_o  (hit_cnt_o),
        .miss_cnt_o (miss_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
        last     = 0;
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_hits"}, hit_cnt_o, m_hits);
        chk({tag, "_miss"}, miss_cnt_o, m_misses);
    endtask

    // One request from IDLE; returns at the negedge of the next IDLE cycle.
    task automatic fetch(input logic [31:0] pc, input logic [31:0] w,
                         input int lat, input int ab_at, input int frz);
        logic [6:0]  ix;
        logic [7:0]  tg;
        logic [31:0] aligned;
        bit          hit;
        bit          aborted;
        ix      = pc[8:2];
        tg      = pc[16:9];
        aligned = {pc[31:2], 2'b00};
        hit     = m_valid[ix] && (m_tag[ix] == tg);
        aborted = 0;
        inst_en_i = 1'b1;
        pc_i      = pc;
        abort_i   = 1'b0;
        @(negedge clk);
        inst_en_i = 1'b0;
        if (hit) begin
            m_hits++;
            last = m_word[ix];
            chk("hit_rdy", {31'd0, inst_rdy_o}, 32'd1);
            chk("hit_inst", inst_o, last);
            chk("hit_memen", {31'd0, mem_en_o}, 32'd0);
            chk_cnt("hit");
        end else begin
            m_misses++;
            chk("miss_memen", {31'd0, mem_en_o}, 32'd1);
            chk("miss_addr", mem_addr_o, aligned);
            chk("miss_rdy", {31'd0, inst_rdy_o}, 32'd0);
            chk_cnt("miss");
            for (int i = 0; i < lat; i++) begin
                abort_i   = (i == ab_at);
                aborted   = aborted | (i == ab_at);
                inst_en_i = 1'($urandom);
                pc_i      = $urandom;
                @(negedge clk);
                abort_i = 1'b0;
                chk("wait_memen", {31'd0, mem_en_o}, 32'd1);
                chk("wait_addr", mem_addr_o, aligned);
                chk("wait_rdy", {31'd0, inst_rdy_o}, 32'd0);
            end
            inst_en_i  = 1'b0;
            abort_i    = (ab_at == lat);
            aborted    = aborted | (ab_at == lat);
            mem_rdy_i  = 1'b1;
            mem_inst_i = w;
            if (frz > 0) begin
                rdy = 1'b0;
                for (int k = 0; k < frz; k++) begin
                    @(negedge clk);
                    chk("frz_memen", {31'd0, mem_en_o}, 32'd1);
                    chk("frz_addr", mem_addr_o, aligned);
                    chk("frz_rdy", {31'd0, inst_rdy_o}, 32'd0);
                end
                rdy = 1'b1;
            end
            @(negedge clk);
            abort_i    = 1'b0;
            mem_rdy_i  = 1'b0;
            mem_inst_i = $urandom;
            m_valid[ix] = 1'b1;
            m_tag[ix]   = tg;
            m_word[ix]  = w;
            if (aborted) begin
                chk("ab_rdy", {31'd0, inst_rdy_o}, 32'd0);
                chk("ab_inst", inst_o, last);
                chk("ab_memen", {31'd0, mem_en_o}, 32'd0);
            end else begin
                last = w;
                chk("fill_rdy", {31'd0, inst_rdy_o}, 32'd1);
                chk("fill_inst", inst_o, w);
                chk("fill_memen", {31'd0, mem_en_o}, 32'd0);
            end
        end
        if (hit || !aborted) begin
            inst_en_i = 1'($urandom);
            pc_i      = $urandom;
            @(negedge clk);
            inst_en_i = 1'b0;
            chk("done_rdy", {31'd0, inst_rdy_o}, 32'd0);
            chk("done_memen", {31'd0, mem_en_o}, 32'd0);
            chk("done_inst", inst_o, last);
        end
        chk_cnt("end");
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rdy"}, {31'd0, inst_rdy_o}, 32'd0);
        chk({tag, "_memen"}, {31'd0, mem_en_o}, 32'd0);
        chk({tag, "_addr"}, mem_addr_o, 32'd0);
        chk({tag, "_inst"}, inst_o, 32'd0);
        chk_cnt(tag);
    endtask

    initial begin
        logic [31:0] pc;
        int          lat;
        int          frz;
        int          ab;
        vec_cnt    = 0;
        err_cnt    = 0;
        rst        = 1'b0;
        rdy        = 1'b0;
        inst_en_i  = 1'b0;
        pc_i       = '0;
        abort_i    = 1'b0;
        mem_inst_i = '0;
        mem_rdy_i  = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        rdy = 1'b1;
        chk_zero("reset");

        fetch(32'h0000_0100, 32'h0000_0013, 3, -1, 0);
        fetch(32'h0000_0100, 32'h0, 0, -1, 0);
        fetch(32'h0000_0100, 32'h0, 0, -1, 0);
        fetch(32'h0000_0300, 32'hA5A5_0300, 1, -1, 0);
        fetch(32'h0000_0100, 32'h0000_0113, 2, -1, 0);
        fetch(32'h0000_0200, 32'hDEAD_BEEF, 4, 1, 0);
        fetch(32'h0000_0200, 32'h0, 0, -1, 0);
        fetch(32'h0000_0400, 32'h0000_4400, 2, -1, 5);
        fetch(32'h0000_0500, 32'h0000_5500, 2, 2, 0);
        fetch(32'h0000_0500, 32'h0, 0, -1, 0);

        inst_en_i = 1'b1;
        pc_i      = 32'h0000_0600;
        abort_i   = 1'b1;
        @(negedge clk);
        inst_en_i = 1'b0;
        abort_i   = 1'b0;
        chk("rej_memen", {31'd0, mem_en_o}, 32'd0);
        chk("rej_rdy", {31'd0, inst_rdy_o}, 32'd0);
        chk_cnt("rej");

        mem_rdy_i  = 1'b1;
        mem_inst_i = 32'hBAD0_BAD0;
        @(negedge clk);
        mem_rdy_i = 1'b0;
        chk("stray_rdy", {31'd0, inst_rdy_o}, 32'd0);
        chk("stray_inst", inst_o, last);
        fetch(32'h0000_0100, 32'h0, 0, -1, 0);

        inst_en_i = 1'b1;
        pc_i      = 32'h0000_01F0;
        @(negedge clk);
        inst_en_i = 1'b0;
        chk("rmiss_memen", {31'd0, mem_en_o}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        chk_zero("midrst");
        mem_rdy_i  = 1'b1;
        mem_inst_i = 32'h1111_2222;
        @(negedge clk);
        mem_rdy_i = 1'b0;
        chk("late_rdy", {31'd0, inst_rdy_o}, 32'd0);
        chk("late_memen", {31'd0, mem_en_o}, 32'd0);
        fetch(32'h0000_01F0, 32'h0000_01F1, 1, -1, 0);
        fetch(32'h0000_0100, 32'h0000_0777, 1, -1, 0);

        for (int n = 0; n < 300; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                inst_en_i = 1'b1;
                pc_i      = $urandom;
                abort_i   = 1'b1;
                @(negedge clk);
                inst_en_i = 1'b0;
                abort_i   = 1'b0;
                chk("rrej_memen", {31'd0, mem_en_o}, 32'd0);
                chk("rrej_rdy", {31'd0, inst_rdy_o}, 32'd0);
                chk_cnt("rrej");
            end else if (r == 1) begin
                mem_rdy_i  = 1'b1;
                mem_inst_i = $urandom;
                @(negedge clk);
                mem_rdy_i = 1'b0;
                chk("rstray_rdy", {31'd0, inst_rdy_o}, 32'd0);
                chk("rstray_inst", inst_o, last);
            end else begin
                pc        = $urandom;
                pc[16:9]  = 8'($urandom_range(0, 3));
                pc[8:2]   = 7'($urandom_range(0, 7));
                lat       = $urandom_range(0, 4);
                frz       = ($urandom_range(0, 4) == 0) ?
                            $urandom_range(1, 3) : 0;
                ab        = -1;
                if (frz == 0 && $urandom_range(0, 3) == 0) begin
                    ab = $urandom_range(0, lat);
                end
                fetch(pc, $urandom, lat, ab, frz);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vec_cnt, err_cnt);
        $finish;
    end

endmodule
